// File: rtl/neopixel_frame_ctrl.sv
// Frame sequencer between the pixel FIFO and the WS2812 bit serializer.
// Latency: start -> FETCH next cycle -> first tx_valid/fifo_rd_en one cycle later; 2 cycles per pixel.
// Backpressure: tx_data/tx_valid hold while tx_ready=0; an empty FIFO stalls FETCH indefinitely.
//
// Ports:
//   clk, rst                    rising-edge clock, asynchronous active-low reset
//   start, num_pixels           frame request and pixel count (latched on acceptance)
//   fifo_dout, fifo_empty       FIFO head word and empty flag
//   fifo_rd_en                  single-cycle pop strobe, registered
//   tx_data, tx_valid, tx_ready valid/ready handshake towards the serializer
//   latch_active                high for the whole reset-low gap after the last pixel
//   busy, frame_done, underrun  status: not idle, end-of-frame pulse, sticky FIFO starvation
//
// Build option: define NEO_CTRL_GRB_SWAP_EN to reorder {R,G,B} FIFO words into GRB wire order.
`timescale 1ns/1ps

module neopixel_frame_ctrl #(
  parameter int U_FIFO_WIDTH = 24,
  parameter int PIX_CNT_W    = 16,
  parameter int RESET_CYCLES = 2500
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [PIX_CNT_W-1:0]    num_pixels,
  input  logic [U_FIFO_WIDTH-1:0] fifo_dout,
  input  logic                    fifo_empty,
  output logic                    fifo_rd_en,
  output logic [U_FIFO_WIDTH-1:0] tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic                    latch_active,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    underrun
);

  localparam int                LAT_W    = $clog2(RESET_CYCLES + 1);
  localparam logic [LAT_W-1:0]  LAT_LOAD = LAT_W'(RESET_CYCLES);
  localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SEND,
    LATCH,
    DONE
  } state_t;

  state_t                  state;
  logic [PIX_CNT_W-1:0]    pix_total;
  logic [PIX_CNT_W-1:0]    pix_cnt;
  logic [PIX_CNT_W-1:0]    pix_cnt_inc;
  logic [LAT_W-1:0]        lat_cnt;
  logic [U_FIFO_WIDTH-1:0] pix_word;

  assign pix_cnt_inc = pix_cnt + PIX_CNT_W'(1);

  // Colour reorder sits in front of the tx_data register so both builds
  // have identical timing.
`ifdef NEO_CTRL_GRB_SWAP_EN
  assign pix_word = {fifo_dout[15:8], fifo_dout[23:16], fifo_dout[7:0]};
`else
  assign pix_word = fifo_dout;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      pix_total    <= '0;
      pix_cnt      <= '0;
      lat_cnt      <= '0;
      fifo_rd_en   <= 1'b0;
      tx_data      <= '0;
      tx_valid     <= 1'b0;
      latch_active <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      // Pop strobe and completion flag are single-cycle pulses.
      fifo_rd_en <= 1'b0;
      frame_done <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            pix_total <= num_pixels;
            pix_cnt   <= '0;
            underrun  <= 1'b0;
            busy      <= 1'b1;
            // An empty frame skips the FIFO and the latch gap entirely.
            state     <= (num_pixels != '0) ? FETCH : DONE;
          end
        end

        FETCH: begin
          if (!fifo_empty) begin
            tx_data    <= pix_word;
            tx_valid   <= 1'b1;
            fifo_rd_en <= 1'b1;
            state      <= SEND;
          end else if (pix_cnt != '0) begin
            // Starving before the first pixel is just a slow start, not an underrun.
            underrun <= 1'b1;
          end
        end

        SEND: begin
          // Leaving SEND always passes through FETCH (or LATCH), which keeps
          // fifo_rd_en low for a cycle before the FIFO head is sampled again.
          if (tx_valid && tx_ready) begin
            tx_valid <= 1'b0;
            pix_cnt  <= pix_cnt_inc;
            if (pix_cnt_inc == pix_total) begin
              latch_active <= 1'b1;
              lat_cnt      <= LAT_LOAD;
              state        <= LATCH;
            end else begin
              state <= FETCH;
            end
          end
        end

        LATCH: begin
          // lat_cnt walks RESET_CYCLES..1, one LATCH cycle per value.
          if (lat_cnt == LAT_LAST) begin
            latch_active <= 1'b0;
            state        <= DONE;
          end else begin
            lat_cnt <= lat_cnt - LAT_LAST;
          end
        end

        DONE: begin
          // frame_done is registered, so it shows on the IDLE cycle where busy drops.
          frame_done <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neopixel_frame_ctrl.sv
`timescale 1ns/1ps

module tb_neopixel_frame_ctrl;

  localparam int W  = 24;
  localparam int PW = 16;
  localparam int R  = 8;

`ifdef NEO_CTRL_GRB_SWAP_EN
  localparam logic [23:0] EXP_FIRST = 24'h221133;
`else
  localparam logic [23:0] EXP_FIRST = 24'h112233;
`endif

  logic          clk;
  logic          rst;
  logic          start;
  logic [PW-1:0] num_pixels;
  logic [W-1:0]  fifo_dout;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [W-1:0]  tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          latch_active;
  logic          busy;
  logic          frame_done;
  logic          underrun;

  neopixel_frame_ctrl #(
    .U_FIFO_WIDTH(W),
    .PIX_CNT_W   (PW),
    .RESET_CYCLES(R)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .num_pixels  (num_pixels),
    .fifo_dout   (fifo_dout),
    .fifo_empty  (fifo_empty),
    .fifo_rd_en  (fifo_rd_en),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .latch_active(latch_active),
    .busy        (busy),
    .frame_done  (frame_done),
    .underrun    (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO model: the stimulus appends to wr_mem, this block owns the read pointer.
  // A reset flushes whatever has not been popped.
  logic [W-1:0] wr_mem [64];
  int wr_cnt = 0;
  int rd_ptr = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst)            rd_ptr <= wr_cnt;
    else if (fifo_rd_en) rd_ptr <= rd_ptr + 1;
  end

  assign fifo_empty = (rd_ptr >= wr_cnt);
  assign fifo_dout  = fifo_empty ? '0 : wr_mem[rd_ptr[5:0]];

  function automatic logic [23:0] sw(input logic [23:0] w);
`ifdef NEO_CTRL_GRB_SWAP_EN
    return {w[15:8], w[23:16], w[7:0]};
`else
    return w;
`endif
  endfunction

  int n_checks = 0;
  int n_errors = 0;

  // Observation state, all owned by the single stimulus/compare process.
  int cyc = 0;
  int stall_from = 0;
  int stall_to   = 0;
  int hs_idx = 0;
  int rd_cnt = 0, hs_cnt = 0, latch_len = 0, done_cnt = 0, stall_cnt = 0, done_cyc = 0;
  int rd_cyc [64];
  logic [W-1:0] hs_dat [64];
  bit prev_rd = 0, prev_stall = 0;
  logic [W-1:0] prev_dat = '0;
  int c0, s_rd, s_hs, s_lat, s_done, s_stall;

  task automatic ceq(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Per-cycle comparison against the transaction-level model.
  task automatic monitor();
    if (!rst) begin
      ceq("rst_rd_en", fifo_rd_en, 0);
      ceq("rst_tx_valid", tx_valid, 0);
      ceq("rst_tx_data", tx_data, 0);
      ceq("rst_latch", latch_active, 0);
      ceq("rst_busy", busy, 0);
      ceq("rst_done", frame_done, 0);
      ceq("rst_underrun", underrun, 0);
      hs_idx     = wr_cnt;
      prev_rd    = 0;
      prev_stall = 0;
      return;
    end
    if (prev_rd) ceq("rd_single_pulse", fifo_rd_en, 0);
    if (prev_stall) begin
      ceq("hold_valid", tx_valid, 1);
      ceq("hold_data", tx_data, prev_dat);
      ceq("hold_no_pop", fifo_rd_en, 0);
    end
    if (fifo_rd_en) begin
      ceq("rd_with_valid", tx_valid, 1);
      rd_cyc[rd_cnt[5:0]] = cyc;
      rd_cnt++;
    end
    if (tx_valid && tx_ready) begin
      if (hs_idx < wr_cnt) ceq("tx_data_order", tx_data, sw(wr_mem[hs_idx[5:0]]));
      else                 ceq("tx_extra_word", hs_idx, wr_cnt - 1);
      hs_dat[hs_cnt[5:0]] = tx_data;
      hs_cnt++;
      hs_idx++;
    end
    if (tx_valid && !tx_ready) stall_cnt++;
    if (latch_active) begin
      latch_len++;
      ceq("latch_no_valid", tx_valid, 0);
      ceq("latch_busy", busy, 1);
    end
    if (frame_done) begin
      done_cnt++;
      done_cyc = cyc;
      ceq("done_not_busy", busy, 0);
    end
    if (!busy) begin
      ceq("idle_no_valid", tx_valid, 0);
      ceq("idle_no_latch", latch_active, 0);
    end
    prev_rd    = fifo_rd_en;
    prev_stall = tx_valid && !tx_ready;
    prev_dat   = tx_data;
  endtask

  // Inputs change 1 ns after the rising edge; outputs are compared on the falling edge.
  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    cyc++;
    #1;
    tx_ready = !(cyc >= stall_from && cyc < stall_to);
  endtask

  task automatic push(input logic [W-1:0] d);
    wr_mem[wr_cnt[5:0]] = d;
    wr_cnt++;
  endtask

  task automatic snap();
    s_rd = rd_cnt; s_hs = hs_cnt; s_lat = latch_len; s_done = done_cnt; s_stall = stall_cnt;
  endtask

  task automatic go(input int n);
    num_pixels = PW'(n);
    start      = 1'b1;
    c0         = cyc;
    step();
    start      = 1'b0;
    num_pixels = 16'hBEEF;  // changes after acceptance must not matter
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    int d0 = done_cnt;
    while (done_cnt == d0 && n < budget) begin
      step();
      n++;
    end
    ceq("done_within_budget", done_cnt - d0, 1);
  endtask

  task automatic run_to(input int c);
    while (cyc < c) step();
  endtask

  initial begin
    rst        = 1'b0;
    start      = 1'b0;
    num_pixels = '0;
    tx_ready   = 1'b1;
    repeat (3) step();
    rst = 1'b1;
    step();

    // 1: three pixels, no backpressure.
    push(24'h112233); push(24'h445566); push(24'h778899);
    snap();
    go(3);
    wait_done(100);
    repeat (3) step();
    ceq("t1_pops", rd_cnt - s_rd, 3);
    ceq("t1_sent", hs_cnt - s_hs, 3);
    ceq("t1_latch_len", latch_len - s_lat, R);
    ceq("t1_done_pulses", done_cnt - s_done, 1);
    ceq("t1_first_pop_lat", rd_cyc[s_rd[5:0]] - c0, 2);
    ceq("t1_second_pop_lat", rd_cyc[(s_rd + 1) & 63] - c0, 4);
    ceq("t1_done_lat", done_cyc - c0, 16);
    ceq("t1_first_word", hs_dat[s_hs[5:0]], EXP_FIRST);
    ceq("t1_underrun", underrun, 0);
    ceq("t1_idle", busy, 0);

    // 2: pixel 2 stalled by tx_ready=0 for 10 cycles.
    push(24'h112233); push(24'h445566); push(24'h778899);
    snap();
    stall_from = cyc + 4;
    stall_to   = cyc + 14;
    go(3);
    wait_done(100);
    stall_from = 0; stall_to = 0;
    ceq("t2_stall_cycles", stall_cnt - s_stall, 10);
    ceq("t2_pops", rd_cnt - s_rd, 3);
    ceq("t2_sent", hs_cnt - s_hs, 3);
    ceq("t2_second_word", hs_dat[(s_hs + 1) & 63], sw(24'h445566));
    ceq("t2_done_lat", done_cyc - c0, 26);

    // 3: FIFO runs dry after pixel 1, refilled 20 cycles after start.
    push(24'h0000FF);
    snap();
    go(2);
    run_to(c0 + 10);
    ceq("t3_underrun_mid", underrun, 1);
    ceq("t3_busy_mid", busy, 1);
    run_to(c0 + 20);
    push(24'h00FF00);
    wait_done(100);
    step();
    ceq("t3_done_lat", done_cyc - c0, 31);
    ceq("t3_underrun_sticky", underrun, 1);
    ceq("t3_pops", rd_cnt - s_rd, 2);
    ceq("t3_sent", hs_cnt - s_hs, 2);

    // 4: empty frame.
    snap();
    go(0);
    ceq("t4_underrun_cleared", underrun, 0);
    wait_done(20);
    ceq("t4_done_lat", done_cyc - c0, 2);
    ceq("t4_pops", rd_cnt - s_rd, 0);
    ceq("t4_latch", latch_len - s_lat, 0);
    ceq("t4_sent", hs_cnt - s_hs, 0);

    // 5a: start pulsed during SEND is ignored.
    push(24'hA00001); push(24'hA00002); push(24'hA00003);
    snap();
    go(3);
    run_to(c0 + 4);
    start      = 1'b1;
    num_pixels = 16'd1;
    step();
    start = 1'b0;
    wait_done(100);
    repeat (20) step();
    ceq("t5_pops", rd_cnt - s_rd, 3);
    ceq("t5_done_pulses", done_cnt - s_done, 1);
    ceq("t5_done_lat", done_cyc - c0, 16);

    // 5b: reset while a word is stalled in SEND, then a clean frame.
    push(24'hCAFE01); push(24'hCAFE02);
    stall_from = cyc;
    stall_to   = cyc + 1000;
    go(2);
    run_to(c0 + 5);
    ceq("t5_pre_valid", tx_valid, 1);
    rst = 1'b0;
    #1;
    ceq("t5_async_valid", tx_valid, 0);
    ceq("t5_async_busy", busy, 0);
    ceq("t5_async_data", tx_data, 0);
    ceq("t5_async_rd", fifo_rd_en, 0);
    stall_from = 0; stall_to = 0;
    repeat (3) step();
    rst = 1'b1;
    step();
    push(24'hA1B2C3); push(24'hD4E5F6);
    snap();
    go(2);
    wait_done(100);
    ceq("t5_clean_done_lat", done_cyc - c0, 14);
    ceq("t5_clean_pops", rd_cnt - s_rd, 2);
    ceq("t5_clean_sent", hs_cnt - s_hs, 2);
    ceq("t5_clean_latch", latch_len - s_lat, R);
    ceq("t5_clean_underrun", underrun, 0);
    repeat (2) step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
